// File: rtl/serial_nibble_receiver.sv
// Serial nibble receiver: start bit, 4 data bits MSB first, optional even parity, stop bit,
// feeding a 4-entry FIFO. Define SERIAL_NIBBLE_RECEIVER_PARITY_EN to enable the parity bit.
module serial_nibble_receiver (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENB,
    input  logic       S_IN,
    input  logic       READY,
    output logic [3:0] DOUT,
    output logic       VALID,
    output logic [2:0] COUNT,
    output logic       FRAME_ERR,
    output logic       OVF
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     state;
    logic [1:0] bit_cnt;
    logic [3:0] sr;
    logic [3:0] mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
    logic       perr;
`endif

    logic pop;
    logic frame_done;
    logic frame_good;
    logic push;

    assign VALID = (COUNT != 3'd0);
    assign DOUT  = mem[rd_ptr];

    // A full FIFO still accepts a frame when the same edge pops an entry.
    always_comb begin
        pop        = VALID && READY;
        frame_done = ENB && (state == STOP);
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
        frame_good = !S_IN && !perr;
`else
        frame_good = !S_IN;
`endif
        push       = frame_done && frame_good && ((COUNT != 3'd4) || pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            COUNT     <= '0;
            FRAME_ERR <= 1'b0;
            OVF       <= 1'b0;
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
            perr      <= 1'b0;
`endif
            for (int unsigned i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            FRAME_ERR <= frame_done && !frame_good;
            if (frame_done && frame_good && !push) begin
                OVF <= 1'b1;
            end

            if (push) begin
                mem[wr_ptr] <= sr;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   COUNT <= COUNT + 3'd1;
                2'b01:   COUNT <= COUNT - 3'd1;
                default: COUNT <= COUNT;
            endcase

            if (ENB) begin
                case (state)
                    IDLE: begin
                        if (S_IN) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sr      <= {sr[2:0], S_IN};
                        bit_cnt <= bit_cnt + 2'd1;
                        if (bit_cnt == 2'd3) begin
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
                    PARITY: begin
                        perr  <= (S_IN != ^sr);
                        state <= STOP;
                    end
`endif
                    STOP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Randomized self-checking bench for serial_nibble_receiver against a queue-based frame model.
module tb_serial_nibble_receiver;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ENB = 1'b0;
    logic       S_IN = 1'b0;
    logic       READY = 1'b0;
    logic [3:0] DOUT;
    logic       VALID;
    logic [2:0] COUNT;
    logic       FRAME_ERR;
    logic       OVF;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SERIAL_NIBBLE_RECEIVER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // reference model state
    logic [3:0] mq[$];
    bit         m_ovf  = 1'b0;
    bit         m_ferr = 1'b0;

    serial_nibble_receiver dut (
        .CLK(CLK), .RST(RST), .ENB(ENB), .S_IN(S_IN), .READY(READY),
        .DOUT(DOUT), .VALID(VALID), .COUNT(COUNT), .FRAME_ERR(FRAME_ERR), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    // One clock: drive at negedge, update the model at posedge, return 1 time unit later.
    task automatic step(input logic s, input logic e, input logic r, input logic rs,
                        input bit is_stop, input bit good, input logic [3:0] d);
        bit do_pop;
        bit do_push;
        @(negedge CLK);
        S_IN = s; ENB = e; READY = r; RST = rs;
        @(posedge CLK);
        if (rs) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && r;
            do_push = 1'b0;
            m_ferr  = 1'b0;
            if (e && is_stop) begin
                if (!good)                            m_ferr  = 1'b1;
                else if (mq.size() < 4 || do_pop)     do_push = 1'b1;
                else                                  m_ovf   = 1'b1;
            end
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        #1;
    endtask

    // ready_mode: 0 = low, 1 = high, 2 = random, 3 = high only on the stop bit
    task automatic send_frame(input logic [3:0] d, input bit bad_par, input bit bad_stop,
                              input int ready_mode, input bit gaps);
        logic bits[7];
        int   n;
        bit   good;
        logic r;
        bits[0] = 1'b1;
        for (int i = 0; i < 4; i++) bits[1 + i] = d[3 - i];
        if (PAR_EN) begin
            bits[5] = (^d) ^ bad_par;
            bits[6] = bad_stop;
            n = 7;
            good = !bad_par && !bad_stop;
        end else begin
            bits[5] = bad_stop;
            bits[6] = 1'b0;
            n = 6;
            good = !bad_stop;
        end
        for (int i = 0; i < n; i++) begin
            case (ready_mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                2:       r = 1'($urandom_range(0, 1));
                default: r = (i == n - 1);
            endcase
            step(bits[i], 1'b1, r, 1'b0, i == n - 1, good, d);
            if (gaps && i != n - 1) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if ({DOUT, VALID, COUNT, FRAME_ERR, OVF} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset: dout=%h valid=%b count=%0d ferr=%b ovf=%b required all 0",
                     DOUT, VALID, COUNT, FRAME_ERR, OVF);
        end
    endtask

    task automatic test_vectors();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        // good frame (A with parity, 6 without)
        send_frame(PAR_EN ? 4'hA : 4'h6, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (VALID !== 1'b1 || DOUT !== (PAR_EN ? 4'hA : 4'h6) || COUNT !== 3'd1 || FRAME_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_good: valid=%b dout=%h count=%0d ferr=%b required 1 %h 1 0",
                     VALID, DOUT, COUNT, FRAME_ERR, PAR_EN ? 4'hA : 4'h6);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if (VALID !== 1'b0 || COUNT !== 3'd0) begin
            n_fail++;
            $display("FAIL vec_pop: valid=%b count=%0d required 0 0", VALID, COUNT);
        end
        // rejected frames: parity error (if enabled), then stop error
        for (int k = 0; k < 2; k++) begin
            if (k == 0 && !PAR_EN) continue;
            send_frame(PAR_EN ? (k == 0 ? 4'hA : 4'hF) : 4'h6, k == 0, k == 1, 0, 1'b0);
            n_checks++;
            if (FRAME_ERR !== 1'b1 || COUNT !== 3'd0 || VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_bad%0d: ferr=%b count=%0d valid=%b required 1 0 0",
                         k, FRAME_ERR, COUNT, VALID);
            end
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
            n_checks++;
            if (FRAME_ERR !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_pulse%0d: ferr=%b required 0", k, FRAME_ERR);
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int k = 1; k <= 5; k++) send_frame(4'(k), 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (COUNT !== 3'd4 || OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_fill: count=%0d ovf=%b required 4 1", COUNT, OVF);
        end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (VALID !== 1'b1 || DOUT !== 4'(k)) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: valid=%b dout=%h required 1 %h", k, VALID, DOUT, 4'(k));
            end
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        end
        n_checks++;
        if (VALID !== 1'b0 || COUNT !== 3'd0 || OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_empty: valid=%b count=%0d ovf=%b required 0 0 1", VALID, COUNT, OVF);
        end
    endtask

    task automatic test_full_push_pop();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int k = 1; k <= 4; k++) send_frame(4'(k), 1'b0, 1'b0, 0, 1'b0);
        send_frame(4'h6, 1'b0, 1'b0, 3, 1'b0);
        n_checks++;
        if (COUNT !== 3'd4 || OVF !== 1'b0 || DOUT !== 4'h2) begin
            n_fail++;
            $display("FAIL full_pp: count=%0d ovf=%b dout=%h required 4 0 2", COUNT, OVF, DOUT);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (DOUT !== mq[0] || VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL full_drain%0d: dout=%h valid=%b required %h 1", k, DOUT, VALID, mq[0]);
            end
            if (k == 3 && DOUT !== 4'h6) begin
                n_fail++;
                $display("FAIL full_last: dout=%h required 6", DOUT);
            end
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        end
    endtask

    task automatic test_enb_and_midreset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        send_frame(4'h3, 1'b0, 1'b0, 0, 1'b1);
        n_checks++;
        if (VALID !== 1'b1 || DOUT !== 4'h3 || COUNT !== 3'd1 || FRAME_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL enb_gap: valid=%b dout=%h count=%0d ferr=%b required 1 3 1 0",
                     VALID, DOUT, COUNT, FRAME_ERR);
        end
        // start + two data bits, then reset while mid-DATA
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if ({DOUT, VALID, COUNT, FRAME_ERR, OVF} !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset: dout=%h valid=%b count=%0d ferr=%b ovf=%b required all 0",
                     DOUT, VALID, COUNT, FRAME_ERR, OVF);
        end
        send_frame(4'h9, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (VALID !== 1'b1 || DOUT !== 4'h9 || COUNT !== 3'd1) begin
            n_fail++;
            $display("FAIL fresh_frame: valid=%b dout=%h count=%0d required 1 9 1", VALID, DOUT, COUNT);
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int f = 0; f < 60; f++) begin
            d = 4'($urandom_range(0, 15));
            send_frame(d, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                       2, $urandom_range(0, 3) == 0);
            n_checks++;
            if (VALID !== (mq.size() > 0) || COUNT !== 3'(mq.size()) || FRAME_ERR !== m_ferr ||
                OVF !== m_ovf || (mq.size() > 0 && DOUT !== mq[0])) begin
                n_fail++;
                $display("FAIL rand_frame%0d: valid=%b count=%0d ferr=%b ovf=%b dout=%h required %b %0d %b %b %h",
                         f, VALID, COUNT, FRAME_ERR, OVF, DOUT, mq.size() > 0, mq.size(),
                         m_ferr, m_ovf, (mq.size() > 0) ? mq[0] : 4'h0);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 4'h0);
                n_checks++;
                if (COUNT !== 3'(mq.size()) || FRAME_ERR !== 1'b0 ||
                    (mq.size() > 0 && DOUT !== mq[0])) begin
                    n_fail++;
                    $display("FAIL rand_idle%0d: count=%0d ferr=%b dout=%h required %0d 0 %h",
                             f, COUNT, FRAME_ERR, DOUT, mq.size(), (mq.size() > 0) ? mq[0] : 4'h0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_overflow();
        test_full_push_pop();
        test_enb_and_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
